// File: rtl/mem_pkg.sv
// Shared encodings, bus payload type and helpers for the memory access stage.
package mem_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned BE_W  = 4;
   localparam int unsigned EXC_W = 5;

   typedef enum logic [1:0] {
      SZ_WORD = 2'b00,
      SZ_HALF = 2'b01,
      SZ_BYTE = 2'b10,
      SZ_RSVD = 2'b11
   } size_e;

   localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;
   localparam logic [EXC_W-1:0] EXC_ADES = 5'd5;
   localparam logic [EXC_W-1:0] EXC_DBE  = 5'd7;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      DONE = 2'b10
   } state_e;

   typedef struct packed {
      logic            we;
      logic [XLEN-1:0] addr;
      logic [BE_W-1:0] be;
      logic [XLEN-1:0] wdata;
   } bus_req_t;

   // Reserved size behaves as a word access.
   function automatic logic is_misaligned(size_e sz, logic [1:0] off);
      case (sz)
         SZ_HALF: return off[0];
         SZ_BYTE: return 1'b0;
         default: return (off != 2'b00);
      endcase
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store byte enables and replication, load lane extract and extension.
module mem_lane_align
   import mem_pkg::*;
(
   input  size_e             st_size_i,
   input  logic [1:0]        st_off_i,
   input  logic [XLEN-1:0]   st_data_i,
   output logic [BE_W-1:0]   st_be_o,
   output logic [XLEN-1:0]   st_data_o,
   input  size_e             ld_size_i,
   input  logic [1:0]        ld_off_i,
   input  logic              ld_sign_i,
   input  logic [XLEN-1:0]   ld_rdata_i,
   output logic [XLEN-1:0]   ld_data_o
);

   logic [15:0] ld_half;
   logic [7:0]  ld_byte;

   always_comb begin
      st_be_o   = 4'b1111;
      st_data_o = st_data_i;
      case (st_size_i)
         SZ_HALF: begin
            st_be_o   = st_off_i[1] ? 4'b1100 : 4'b0011;
            st_data_o = {2{st_data_i[15:0]}};
         end
         SZ_BYTE: begin
            st_be_o   = 4'b0001 << st_off_i;
            st_data_o = {4{st_data_i[7:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      ld_half   = ld_off_i[1] ? ld_rdata_i[31:16] : ld_rdata_i[15:0];
      ld_byte   = ld_rdata_i[{ld_off_i, 3'b000} +: 8];
      ld_data_o = ld_rdata_i;
      case (ld_size_i)
         SZ_HALF: ld_data_o = {{16{ld_sign_i & ld_half[15]}}, ld_half};
         SZ_BYTE: ld_data_o = {{24{ld_sign_i & ld_byte[7]}}, ld_byte};
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage bus master: issues req/ack transactions, stalls the pipeline, raises AdEL/AdES.
// Optional BUS_TIMEOUT_EN aborts a BUSY access after TIMEOUT_CYCLES with a DBE exception.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              valid_m,
   input  logic              memread_m,
   input  logic              memwrite_m,
   input  logic [1:0]        size_m,
   input  logic              sign_m,
   input  logic [XLEN-1:0]   addr_m,
   input  logic [XLEN-1:0]   wdata_m,
   input  logic              flush_m,
   output logic              stall_m,
   output logic              bus_req,
   output logic              bus_we,
   output logic [XLEN-1:0]   bus_addr,
   output logic [BE_W-1:0]   bus_be,
   output logic [XLEN-1:0]   bus_wdata,
   input  logic              bus_ack,
   input  logic [XLEN-1:0]   bus_rdata,
   output logic [XLEN-1:0]   ldata_w,
   output logic              ldata_valid,
   output logic              exc_m,
   output logic [EXC_W-1:0]  exccode_m
);

   if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
      $error("mem_access_unit: TIMEOUT_CYCLES must be at least 1");
   end

   state_e          state_q, state_d;
   logic            req_q, req_d;
   bus_req_t        bus_q, bus_d;
   logic [1:0]      off_q, off_d;
   size_e           size_q, size_d;
   logic            sign_q, sign_d;
   logic            rd_q, rd_d;
   logic            cancel_q, cancel_d;
   logic [XLEN-1:0] ldata_q, ldata_d;
   logic            ldv_q, ldv_d;

   logic            access_c;
   logic            mis_c;
   logic            timeout_c;
   size_e           size_c;
   logic [BE_W-1:0] st_be_c;
   logic [XLEN-1:0] st_data_c;
   logic [XLEN-1:0] ld_data_c;

   assign size_c   = size_e'(size_m);
   assign access_c = valid_m & (memread_m | memwrite_m) & ~flush_m;
   assign mis_c    = is_misaligned(size_c, addr_m[1:0]);

   mem_lane_align u_align (
      .st_size_i  (size_c),
      .st_off_i   (addr_m[1:0]),
      .st_data_i  (wdata_m),
      .st_be_o    (st_be_c),
      .st_data_o  (st_data_c),
      .ld_size_i  (size_q),
      .ld_off_i   (off_q),
      .ld_sign_i  (sign_q),
      .ld_rdata_i (bus_rdata),
      .ld_data_o  (ld_data_c)
   );

`ifdef BUS_TIMEOUT_EN
   localparam int unsigned CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned CNT_W   = (CNT_RAW > 8) ? CNT_RAW : 8;

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Counts completed BUSY cycles; held at zero outside BUSY so entry starts clean.
   always_comb begin
      cnt_d = '0;
      if (state_q == BUSY) cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign timeout_c = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   assign timeout_c = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      req_d     = req_q;
      bus_d     = bus_q;
      off_d     = off_q;
      size_d    = size_q;
      sign_d    = sign_q;
      rd_d      = rd_q;
      cancel_d  = cancel_q;
      ldata_d   = ldata_q;
      ldv_d     = 1'b0;
      stall_m   = 1'b0;
      exc_m     = 1'b0;
      exccode_m = '0;

      case (state_q)
         IDLE: begin
            if (access_c && mis_c) begin
               exc_m     = 1'b1;
               exccode_m = memwrite_m ? EXC_ADES : EXC_ADEL;
            end else if (access_c) begin
               stall_m  = 1'b1;
               req_d    = 1'b1;
               bus_d    = '{we: memwrite_m, addr: {addr_m[31:2], 2'b00},
                            be: st_be_c, wdata: st_data_c};
               off_d    = addr_m[1:0];
               size_d   = size_c;
               sign_d   = sign_m;
               rd_d     = memread_m & ~memwrite_m;
               cancel_d = 1'b0;
               state_d  = BUSY;
            end
         end

         // The request is never withdrawn before ack; a flush only drops the result.
         BUSY: begin
            stall_m = 1'b1;
            if (flush_m) cancel_d = 1'b1;
            if (bus_ack) begin
               req_d   = 1'b0;
               state_d = DONE;
               if (rd_q && !cancel_q && !flush_m) begin
                  ldata_d = ld_data_c;
                  ldv_d   = 1'b1;
               end
            end else if (timeout_c) begin
               req_d     = 1'b0;
               exc_m     = 1'b1;
               exccode_m = EXC_DBE;
               state_d   = DONE;
            end
         end

         // One unstalled cycle lets the pipeline retire the instruction without re-issue.
         DONE: state_d = IDLE;

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         req_q    <= 1'b0;
         bus_q    <= '0;
         off_q    <= 2'b00;
         size_q   <= SZ_WORD;
         sign_q   <= 1'b0;
         rd_q     <= 1'b0;
         cancel_q <= 1'b0;
         ldata_q  <= '0;
         ldv_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         req_q    <= req_d;
         bus_q    <= bus_d;
         off_q    <= off_d;
         size_q   <= size_d;
         sign_q   <= sign_d;
         rd_q     <= rd_d;
         cancel_q <= cancel_d;
         ldata_q  <= ldata_d;
         ldv_q    <= ldv_d;
      end
   end

   assign bus_req     = req_q;
   assign bus_we      = bus_q.we;
   assign bus_addr    = bus_q.addr;
   assign bus_be      = bus_q.be;
   assign bus_wdata   = bus_q.wdata;
   assign ldata_w     = ldata_q;
   assign ldata_valid = ldv_q;

endmodule
